lanectrl_pause_req_seq: RTL and testbench

//  Upstream sequencer for the lane-control clock-pause synchroniser. Accepts delay-update

---
 rtl/lanectrl_pause_req_seq.sv | 142 ++++++++++++++
 tb/tb_lanectrl_pause_req_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lanectrl_pause_req_seq.sv
// Upstream sequencer for the lane-control clock-pause synchroniser: opens a pause window,
// issues delay-line tap pulses inside it, then enforces a quiet gap before the next request.
module lanectrl_pause_req_seq #(
    parameter int PAUSE_SETUP_CYC = 4,
    parameter int PAUSE_HOLD_CYC  = 4,
    parameter int GAP_CYC         = 8,
    parameter int STEP_W          = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              UPD_REQ,
    input  logic              UPD_DIR,
    input  logic [STEP_W-1:0] UPD_STEPS,
    output logic              UPD_BUSY,
    output logic              UPD_ACK,
    output logic              HS_IO_CLK_PAUSE,
    output logic              DLY_MOVE,
    output logic              DLY_DIR
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_MOVE  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    // Counters hold "cycles remaining after this one" for the current phase.
    localparam logic [7:0] SETUP_LD    = 8'(PAUSE_SETUP_CYC - 1);
    localparam logic [7:0] HOLD_LD     = 8'(PAUSE_HOLD_CYC - 1);
    // The ACK cycle after HOLD is the first gap cycle, so even GAP_CYC=0 keeps one.
    localparam logic [7:0] GAP_LD_HOLD = (GAP_CYC == 0) ? 8'd0 : 8'(GAP_CYC - 1);
    // A zero-step request spends its ACK cycle ahead of the full gap.
    localparam logic [7:0] GAP_LD_ZERO = 8'(GAP_CYC);

    logic [2:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              dir_q, dir_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;
    logic              pause_q, pause_d;
    logic              move_q, move_d;
    logic [7:0]        move_ld;

    assign move_ld = 8'({steps_q, 1'b0}) - 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        steps_d = steps_q;
        dir_d   = dir_q;
        ack_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (UPD_REQ) begin
                    steps_d = UPD_STEPS;
                    if (UPD_STEPS == '0) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LD_ZERO;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = SETUP_LD;
                        dir_d   = UPD_DIR;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_MOVE;
                    cnt_d   = move_ld;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_MOVE: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LD_HOLD;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear registered with no lag.
    always_comb begin
        busy_d  = (state_d != S_IDLE);
        pause_d = (state_d == S_SETUP) || (state_d == S_MOVE) || (state_d == S_HOLD);
        move_d  = (state_d == S_MOVE) && cnt_d[0];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            steps_q <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            pause_q <= 1'b0;
            move_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            steps_q <= steps_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            pause_q <= pause_d;
            move_q  <= move_d;
        end
    end

    assign UPD_BUSY        = busy_q;
    assign UPD_ACK         = ack_q;
    assign HS_IO_CLK_PAUSE = pause_q;
    assign DLY_MOVE        = move_q;
    assign DLY_DIR         = dir_q;

endmodule

// File: tb/tb_lanectrl_pause_req_seq.sv
// Bench for lanectrl_pause_req_seq: two parameterisations driven in lockstep, each checked
// every cycle against a per-request output schedule, plus literal checks on the scenarios.
module tb_lanectrl_pause_req_seq;

    typedef logic [4:0] vec_t; // {busy, ack, pause, move, dir}

    logic       CLK = 1'b0;
    logic       RESET;
    logic       req, dir;
    logic [3:0] steps;
    logic a_busy, a_ack, a_pause, a_move, a_dir;
    logic b_busy, b_ack, b_pause, b_move, b_dir;

    vec_t qa[$], qb[$], ha[$], hb[$];
    bit   lda, ldb;
    int   checks = 0;
    int   errs   = 0;

    always #5 CLK = ~CLK;

    lanectrl_pause_req_seq dut_a (
        .CLK(CLK), .RESET(RESET), .UPD_REQ(req), .UPD_DIR(dir), .UPD_STEPS(steps),
        .UPD_BUSY(a_busy), .UPD_ACK(a_ack), .HS_IO_CLK_PAUSE(a_pause),
        .DLY_MOVE(a_move), .DLY_DIR(a_dir)
    );

    lanectrl_pause_req_seq #(
        .PAUSE_SETUP_CYC(1), .PAUSE_HOLD_CYC(1), .GAP_CYC(0), .STEP_W(4)
    ) dut_b (
        .CLK(CLK), .RESET(RESET), .UPD_REQ(req), .UPD_DIR(dir), .UPD_STEPS(steps),
        .UPD_BUSY(b_busy), .UPD_ACK(b_ack), .HS_IO_CLK_PAUSE(b_pause),
        .DLY_MOVE(b_move), .DLY_DIR(b_dir)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs for every cycle of one accepted request, from the behavioural rules.
    task automatic push_sched(input int which, input int su, input int ho, input int gp,
                              input int st, input bit d);
        vec_t s[$];
        bit   ld;
        int   n;
        ld = (which != 0) ? ldb : lda;
        if (st == 0) begin
            s.push_back({4'b1100, ld});
            for (int i = 0; i < gp; i++) s.push_back({4'b1000, ld});
        end else begin
            for (int i = 0; i < su; i++) s.push_back({4'b1010, d});
            for (int i = 0; i < 2 * st; i++) s.push_back({1'b1, 1'b0, 1'b1, (i % 2 == 0), d});
            for (int i = 0; i < ho; i++) s.push_back({4'b1010, d});
            n = (gp > 0) ? gp : 1;
            s.push_back({4'b1100, d});
            for (int i = 1; i < n; i++) s.push_back({4'b1000, d});
            ld = d;
        end
        foreach (s[i]) begin
            if (which != 0) qb.push_back(s[i]);
            else qa.push_back(s[i]);
        end
        if (which != 0) ldb = ld;
        else lda = ld;
    endtask

    task automatic step(input bit r, input bit d, input logic [3:0] s);
        vec_t ea, eb, va, vb;
        bit   ia, ib;
        @(negedge CLK);
        ia = (qa.size() == 0);
        ib = (qb.size() == 0);
        ea = ia ? {4'b0000, lda} : qa.pop_front();
        eb = ib ? {4'b0000, ldb} : qb.pop_front();
        va = {a_busy, a_ack, a_pause, a_move, a_dir};
        vb = {b_busy, b_ack, b_pause, b_move, b_dir};
        chk("dutA_outputs", int'(va), int'(ea));
        chk("dutB_outputs", int'(vb), int'(eb));
        ha.push_back(va);
        hb.push_back(vb);
        req   = r;
        dir   = d;
        steps = s;
        if (ia && r) begin
            $display("txn A accepted: dir=%0d steps=%0d t=%0t", d, s, $time);
            push_sched(0, 4, 4, 8, s, d);
        end
        if (ib && r) push_sched(1, 1, 1, 0, s, d);
    endtask

    function automatic int find(input vec_t h[$], input int b, input bit v, input int from);
        for (int i = from; i < h.size(); i++) if (h[i][b] == v) return i;
        return -1;
    endfunction

    function automatic int count1(input vec_t h[$], input int b);
        int c = 0;
        foreach (h[i]) if (h[i][b]) c++;
        return c;
    endfunction

    task automatic do_reset_release();
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        int p0, p1, e, m0, m1, m2, ak;
        RESET = 1'b1; req = 1'b0; dir = 1'b0; steps = 4'd0;
        lda = 1'b0; ldb = 1'b0;
        #1;
        chk("reset_A", int'({a_busy, a_ack, a_pause, a_move, a_dir}), 0);
        chk("reset_B", int'({b_busy, b_ack, b_pause, b_move, b_dir}), 0);
        do_reset_release();

        // Scenario 1: DIR=1 STEPS=3 for one cycle.
        ha.delete(); hb.delete();
        step(1'b1, 1'b1, 4'd3);
        repeat (26) step(1'b0, 1'b0, 4'd0);
        p0 = find(ha, 2, 1'b1, 0);
        chk("t1_pause_start", p0, 1);
        chk("t1_pause_width", count1(ha, 2), 14);
        m0 = find(ha, 1, 1'b1, 0);
        m1 = find(ha, 1, 1'b1, m0 + 1);
        m2 = find(ha, 1, 1'b1, m1 + 1);
        chk("t1_move1_cycle", m0 - p0 + 1, 5);
        chk("t1_move2_cycle", m1 - p0 + 1, 7);
        chk("t1_move3_cycle", m2 - p0 + 1, 9);
        chk("t1_move_count", count1(ha, 1), 3);
        chk("t1_ack_at_pause_fall", find(ha, 3, 1'b1, 0), find(ha, 2, 1'b0, p0));
        chk("t1_dir_in_window", int'(ha[p0][0]), 1);

        // Scenario 2: STEPS=0 issues no pause.
        ha.delete(); hb.delete();
        step(1'b1, 1'b0, 4'd0);
        repeat (12) step(1'b0, 1'b0, 4'd0);
        chk("t2_ack_pos", find(ha, 3, 1'b1, 0), 1);
        chk("t2_pause_count", count1(ha, 2), 0);
        chk("t2_move_count", count1(ha, 1), 0);
        chk("t2_busy_A", count1(ha, 4), 9);
        chk("t2_busy_B", count1(hb, 4), 1);
        chk("t2_dir_held", int'(ha[5][0]), 1);

        // Scenario 3: REQ held high, STEPS=1.
        ha.delete(); hb.delete();
        repeat (60) step(1'b1, 1'b1, 4'd1);
        p0 = find(ha, 2, 1'b1, 0);
        e  = find(ha, 2, 1'b0, p0);
        p1 = find(ha, 2, 1'b1, e);
        chk("t3_window_width", e - p0, 10);
        chk("t3_low_gap", p1 - e, 9);
        repeat (30) step(1'b0, 1'b0, 4'd0);

        // Scenario 6 (second instance): SETUP=1 HOLD=1 GAP=0, STEPS=15.
        ha.delete(); hb.delete();
        step(1'b1, 1'b1, 4'd15);
        repeat (50) step(1'b0, 1'b0, 4'd0);
        chk("t6_pause_width", count1(hb, 2), 32);
        ak = find(hb, 3, 1'b1, 0);
        chk("t6_busy_drop", find(hb, 4, 1'b0, ak) - ak, 1);
        chk("t6_move_count", count1(hb, 1), 15);

        // Scenario 4: reset during MOVE after two of five pulses.
        ha.delete(); hb.delete();
        step(1'b1, 1'b0, 4'd5);
        repeat (7) step(1'b0, 1'b1, 4'd0);
        chk("t4_pulses_before_reset", count1(ha, 1), 2);
        @(posedge CLK);
        #2;
        req = 1'b0;
        RESET = 1'b1;
        #1;
        chk("t4_async_clear_A", int'({a_busy, a_ack, a_pause, a_move, a_dir}), 0);
        chk("t4_async_clear_B", int'({b_busy, b_ack, b_pause, b_move, b_dir}), 0);
        qa.delete(); qb.delete();
        lda = 1'b0; ldb = 1'b0;
        do_reset_release();
        ha.delete(); hb.delete();
        step(1'b1, 1'b1, 4'd5);
        repeat (40) step(1'b0, 1'b0, 4'd0);
        chk("t4_full_rerun_moves", count1(ha, 1), 5);
        chk("t4_full_rerun_width", count1(ha, 2), 18);
        chk("t4_single_ack", count1(ha, 3), 1);

        // Randomised traffic, inputs changing every cycle (covers late DIR/STEPS changes
        // and requests during GAP).
        repeat (1500) begin
            step(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        repeat (60) step(1'b0, 1'b0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
